alu_result_wb_buffer: RTL and testbench

Output-side counterpart to the ALU operand registers. It captures each ALU result with its flags and destination register index into a small FIFO, then presents entries one at a time to the register-file write port using a valid/ready handshake. It also keeps an architectural flag register, updated as each entry retires. It sits between the ALU result bus and the register file / status register, so a stalled write port never drops a result.

---
 rtl/alu_result_wb_buffer.sv | 115 +++++++++++
 tb/tb_alu_result_wb_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_wb_buffer.sv
// ============================================================================
// alu_result_wb_buffer : queues ALU results/flags for register-file writeback
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef OPERAND_SIZE
`define OPERAND_SIZE 8
`endif

module alu_result_wb_buffer #(
  parameter int DATA_W = `OPERAND_SIZE,
  parameter int DEST_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [DATA_W-1:0]          res_data,
  input  logic                       res_carry,
  input  logic                       res_zero,
  input  logic [DEST_W-1:0]          res_dest,
  input  logic                       res_wen,
  input  logic                       flush,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [DATA_W-1:0]          wb_data,
  output logic [DEST_W-1:0]          wb_dest,
  output logic                       flag_carry,
  output logic                       flag_zero,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_full    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

  logic [DATA_W-1:0] r_mem_data  [DEPTH];
  logic [DEST_W-1:0] r_mem_dest  [DEPTH];
  logic              r_mem_carry [DEPTH];
  logic              r_mem_zero  [DEPTH];
  logic              r_mem_wen   [DEPTH];

  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W-1:0]  r_rp;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_flag_carry;
  logic              r_flag_zero;

  logic              w_not_empty;
  logic              w_push;
  logic              w_pop;

  assign w_not_empty = (r_cnt != '0);
  assign res_ready   = (r_cnt != c_full) && !flush;
  assign w_push      = res_valid && res_ready;

  // Flags-only entries retire on their own; write entries wait for the handshake.
  assign wb_valid    = w_not_empty && r_mem_wen[r_rp];
  assign w_pop       = w_not_empty && (!r_mem_wen[r_rp] || wb_ready);

  // Empty queue presents zero so reset state is defined without clearing storage.
  assign wb_data     = w_not_empty ? r_mem_data[r_rp] : '0;
  assign wb_dest     = w_not_empty ? r_mem_dest[r_rp] : '0;

  assign flag_carry  = r_flag_carry;
  assign flag_zero   = r_flag_zero;
  assign pending     = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wp]  <= res_data;
      r_mem_dest[r_wp]  <= res_dest;
      r_mem_carry[r_wp] <= res_carry;
      r_mem_zero[r_wp]  <= res_zero;
      r_mem_wen[r_wp]   <= res_wen;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp         <= '0;
      r_rp         <= '0;
      r_cnt        <= '0;
      r_flag_carry <= 1'b0;
      r_flag_zero  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rp         <= r_rp + c_ptr_one;
        r_flag_carry <= r_mem_carry[r_rp];
        r_flag_zero  <= r_mem_zero[r_rp];
      end
      if (w_push) begin
        r_wp <= r_wp + c_ptr_one;
      end
      // No push can occur during flush, so wp is stable and rp may snap to it.
      if (flush) begin
        r_cnt <= '0;
        r_rp  <= r_wp;
      end else begin
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + c_cnt_one;
          2'b01:   r_cnt <= r_cnt - c_cnt_one;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_wb_buffer.sv
// ============================================================================
// tb_alu_result_wb_buffer : vector table, directed sequences and random run
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_result_wb_buffer;

  localparam int DATA_W = 8;
  localparam int DEST_W = 3;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;
  logic              res_zero;
  logic [DEST_W-1:0] res_dest;
  logic              res_wen;
  logic              flush;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [DEST_W-1:0] wb_dest;
  logic              flag_carry;
  logic              flag_zero;
  logic [2:0]        pending;

  alu_result_wb_buffer #(.DATA_W(DATA_W), .DEST_W(DEST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero), .res_dest(res_dest),
    .res_wen(res_wen), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dest(wb_dest),
    .flag_carry(flag_carry), .flag_zero(flag_zero), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rv; logic [7:0] d; logic [2:0] dst; bit c; bit z; bit w; bit fl; bit wr;
    bit e_rdy; bit e_val; logic [7:0] e_data; logic [2:0] e_dest; int e_pend; bit e_fc; bit e_fz;
  } vec_t;

  typedef struct { logic [7:0] d; logic [2:0] dst; bit c; bit z; bit w; } ent_t;

  // Reference model: the queue itself plus the retired flags.
  ent_t m_q[$];
  bit   m_fc, m_fz;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] got[$];
  int max_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(bit rv, logic [7:0] d, logic [2:0] dst, bit c, bit z, bit w,
                              bit fl, bit wr, bit e_rdy, bit e_val, logic [7:0] e_data,
                              logic [2:0] e_dest, int e_pend, bit e_fc, bit e_fz);
    vec_t v;
    v.rv = rv; v.d = d; v.dst = dst; v.c = c; v.z = z; v.w = w; v.fl = fl; v.wr = wr;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_data = e_data; v.e_dest = e_dest;
    v.e_pend = e_pend; v.e_fc = e_fc; v.e_fz = e_fz;
    return v;
  endfunction

  // Apply one cycle of inputs (called just after a falling edge), check, advance.
  task automatic step(input vec_t v, input bit use_exp, input bit rst_n);
    bit   m_rdy, m_val, retire;
    ent_t e;
    reset = rst_n; res_valid = v.rv; res_data = v.d; res_dest = v.dst;
    res_carry = v.c; res_zero = v.z; res_wen = v.w; flush = v.fl; wb_ready = v.wr;
    #1;
    m_rdy = (m_q.size() < DEPTH) && !v.fl;
    m_val = (m_q.size() > 0) && m_q[0].w;
    chk("model_res_ready", res_ready, m_rdy);
    chk("model_wb_valid", wb_valid, m_val);
    if (m_val) begin
      chk("model_wb_data", wb_data, m_q[0].d);
      chk("model_wb_dest", wb_dest, m_q[0].dst);
    end
    chk("model_pending", pending, m_q.size());
    chk("model_flag_carry", flag_carry, m_fc);
    chk("model_flag_zero", flag_zero, m_fz);
    if (use_exp) begin
      chk("vec_res_ready", res_ready, v.e_rdy);
      chk("vec_wb_valid", wb_valid, v.e_val);
      if (v.e_val) begin
        chk("vec_wb_data", wb_data, v.e_data);
        chk("vec_wb_dest", wb_dest, v.e_dest);
      end
      chk("vec_pending", pending, v.e_pend);
      chk("vec_flag_carry", flag_carry, v.e_fc);
      chk("vec_flag_zero", flag_zero, v.e_fz);
    end
    if (wb_valid && wb_ready) got.push_back(wb_data);
    if (int'(pending) > max_pend) max_pend = int'(pending);
    if (!rst_n) begin
      m_q.delete(); m_fc = 0; m_fz = 0;
    end else begin
      retire = (m_q.size() > 0) && (!m_q[0].w || v.wr);
      if (retire) begin
        m_fc = m_q[0].c; m_fz = m_q[0].z;
        void'(m_q.pop_front());
      end
      if (v.rv && m_rdy) begin
        e.d = v.d; e.dst = v.dst; e.c = v.c; e.z = v.z; e.w = v.w;
        m_q.push_back(e);
      end
      if (v.fl) m_q.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    idle = mk(0, 8'h00, 3'd0, 0, 0, 1, 0, 1, 1, 0, 8'h00, 3'd0, 0, 0, 0);
    reset = 1'b0; res_valid = 0; res_data = 0; res_dest = 0; res_carry = 0;
    res_zero = 0; res_wen = 0; flush = 0; wb_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_q.delete(); m_fc = 0; m_fz = 0;
    #1;
    chk("reset_pending", pending, 0);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_res_ready", res_ready, 1);
    chk("reset_flags", {flag_carry, flag_zero}, 2'b00);
    chk("reset_wb_data", wb_data, 0);
    chk("reset_wb_dest", wb_dest, 0);

    //            rv  d      dst c z w fl wr  rdy val data  dest pend fc fz
    tbl.push_back(mk(1, 8'h5A, 3, 1, 0, 1, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1,  1, 1, 8'h5A, 3, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1,  1, 0, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(1, 8'h01, 1, 0, 0, 1, 0, 0,  1, 0, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(1, 8'h02, 2, 0, 1, 1, 0, 0,  1, 1, 8'h01, 1, 1, 1, 0));
    tbl.push_back(mk(1, 8'h03, 3, 0, 0, 1, 0, 0,  1, 1, 8'h01, 1, 2, 1, 0));
    tbl.push_back(mk(1, 8'h04, 4, 1, 0, 1, 0, 0,  1, 1, 8'h01, 1, 3, 1, 0));
    tbl.push_back(mk(1, 8'h05, 5, 0, 0, 1, 0, 0,  0, 1, 8'h01, 1, 4, 1, 0));
    tbl.push_back(mk(1, 8'h05, 5, 0, 0, 1, 0, 1,  0, 1, 8'h01, 1, 4, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1,  1, 1, 8'h02, 2, 3, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1,  1, 1, 8'h03, 3, 2, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1,  1, 1, 8'h04, 4, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1,  1, 0, 8'h00, 0, 0, 1, 0));
    // flags-only entry between two writes
    tbl.push_back(mk(1, 8'h20, 5, 0, 0, 1, 0, 1,  1, 0, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(1, 8'h00, 6, 0, 1, 0, 0, 1,  1, 1, 8'h20, 5, 1, 1, 0));
    tbl.push_back(mk(1, 8'h21, 7, 1, 0, 1, 0, 1,  1, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1,  1, 1, 8'h21, 7, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1,  1, 0, 8'h00, 0, 0, 1, 0));
    // flush with a simultaneous push
    tbl.push_back(mk(1, 8'h30, 1, 0, 1, 1, 0, 0,  1, 0, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(1, 8'h31, 2, 0, 1, 1, 0, 0,  1, 1, 8'h30, 1, 1, 1, 0));
    tbl.push_back(mk(1, 8'h32, 3, 0, 1, 1, 0, 0,  1, 1, 8'h30, 1, 2, 1, 0));
    tbl.push_back(mk(1, 8'h33, 4, 0, 1, 1, 1, 0,  0, 1, 8'h30, 1, 3, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0,  1, 0, 8'h00, 0, 0, 1, 0));
    foreach (tbl[i]) step(tbl[i], 1'b1, 1'b1);

    // Streaming 0x10..0x17 with the write port always ready.
    got.delete(); max_pend = 0;
    for (int i = 0; i < 8; i++)
      step(mk(1, 8'h10 + 8'(i), 3'(i), i[0], i[1], 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    repeat (2) step(idle, 1'b0, 1'b1);
    chk("stream_count", got.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("stream_order", (i < got.size()) ? got[i] : 8'hxx, 8'h10 + 8'(i));
    chk("stream_max_pending", max_pend, 1);

    // Reset while two entries are queued and wb_valid is up.
    step(mk(1, 8'h41, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    step(mk(1, 8'h42, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    chk("prereset_wb_valid", wb_valid, 1);
    chk("prereset_pending", pending, 2);
    step(mk(0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("postreset_pending", pending, 0);
    chk("postreset_wb_valid", wb_valid, 0);
    chk("postreset_flags", {flag_carry, flag_zero}, 2'b00);
    chk("postreset_res_ready", res_ready, 1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      vec_t r;
      r = mk($urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
             $urandom_range(0, 2) != 0, 0, 0, 0, 0, 0, 0, 0);
      step(r, 1'b0, $urandom_range(0, 199) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
